// File: rtl/fifo_wptr_full_if.sv
//------------------------------------------------------------------------------
// Module  : fifo_wptr_full_if
// Brief   : Write-side bundle of the dual-clock FIFO (producer, read pointer, flags).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_wptr_full_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wcount;
    logic                woverflow;

    modport master (
        output winc, rptr, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, wcount, woverflow
    );

    modport slave (
        input  winc, rptr, wovf_clr,
        output waddr, wptr, wfull, walmost_full, wcount, woverflow
    );
endinterface

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
//------------------------------------------------------------------------------
// Module  : fifo_wptr_full
// Brief   : Write-domain pointer, full/almost-full, fill count and overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 14,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic      wclk,
    input  wire logic      wrst_n,
    fifo_wptr_full_if.slave wif
);
    localparam logic [ADDRSIZE:0] c_afull_thresh = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0]                    r_wbin;
    logic [ADDRSIZE:0]                    r_wptr;
    logic [ADDRSIZE:0]                    r_wcount;
    logic                                 r_wfull;
    logic                                 r_walmost_full;
    logic                                 r_woverflow;
    logic [SYNC_STAGES-1:0][ADDRSIZE:0]   r_sync;

    logic                                 w_we;
    logic [ADDRSIZE:0]                    w_wbinnext;
    logic [ADDRSIZE:0]                    w_wgraynext;
    logic [ADDRSIZE:0]                    w_q2_rptr;
    logic [ADDRSIZE:0]                    w_q2_rbin;
    logic [ADDRSIZE:0]                    w_count_next;
    logic                                 w_full_next;

    assign w_q2_rptr = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
        assign w_q2_rbin[i] = ^w_q2_rptr[ADDRSIZE:i];
    end

    assign w_we         = wif.winc & ~r_wfull;
    assign w_wbinnext   = r_wbin + {{ADDRSIZE{1'b0}}, w_we};
    assign w_wgraynext  = (w_wbinnext >> 1) ^ w_wbinnext;
    assign w_count_next = w_wbinnext - w_q2_rbin;

    // Full when the next write pointer has lapped the synced read pointer once.
    assign w_full_next  = (w_wgraynext ==
                           {~w_q2_rptr[ADDRSIZE:ADDRSIZE-1], w_q2_rptr[ADDRSIZE-2:0]});

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], wif.rptr};
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wcount       <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wcount       <= w_count_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= (w_count_next >= c_afull_thresh);
            // A new overflow in the same cycle as a clear must not be lost.
            r_woverflow    <= (wif.winc & r_wfull) | (r_woverflow & ~wif.wovf_clr);
        end
    end

    assign wif.waddr        = r_wbin[ADDRSIZE-1:0];
    assign wif.wptr         = r_wptr;
    assign wif.wfull        = r_wfull;
    assign wif.walmost_full = r_walmost_full;
    assign wif.wcount       = r_wcount;
    assign wif.woverflow    = r_woverflow;

endmodule

`default_nettype wire
